// File: rtl/secuenciador_mac.sv
`default_nettype none
// ============================================================================
// Module      : secuenciador_mac
// Description : Control sequencer for the multiply-accumulate datapath.
//               Walks NUM_TERMS term steps, each held DWELL cycles, driving
//               constant select, rotating function select and accumulator
//               clear/enable, with stall, busy flag and one-cycle done pulse.
//               Optional restart-on-start behaviour is enabled by defining
//               the macro SECUENCIADOR_MAC_RESTART_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module secuenciador_mac #(
    parameter int NUM_TERMS = 6,
    parameter int CONST_W   = 3,
    parameter int FUN_CNT   = 3,
    parameter int FUN_W     = 2,
    parameter int DWELL     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Bandera,
    input  logic               Hold,
    output logic [CONST_W-1:0] sel_const,
    output logic [FUN_W-1:0]   sel_fun,
    output logic               sel_acum,
    output logic               clr_acum,
    output logic               Ocupado,
    output logic               Band_Listo
);

    // Dwell counter needs at least one bit even when DWELL is 1.
    localparam int                 c_D_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CONST_W-1:0] c_K_LAST  = CONST_W'(NUM_TERMS - 1);
    localparam logic [CONST_W-1:0] c_K_ONE   = CONST_W'(1);
    localparam logic [FUN_W-1:0]   c_F_LAST  = FUN_W'(FUN_CNT - 1);
    localparam logic [FUN_W-1:0]   c_F_ONE   = FUN_W'(1);
    localparam logic [c_D_W-1:0]   c_D_LAST  = c_D_W'(DWELL - 1);
    localparam logic [c_D_W-1:0]   c_D_ONE   = c_D_W'(1);

`ifdef SECUENCIADOR_MAC_RESTART_EN
    localparam logic c_RESTART_EN = 1'b1;
`else
    localparam logic c_RESTART_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CONST_W-1:0] r_k;
    logic [c_D_W-1:0]   r_d;
    logic [FUN_W-1:0]   r_f;
    logic               r_clr;
    logic               r_ocupado;
    logic               r_listo;
    logic               w_restart;

    // A new start outside IDLE aborts the current run only when restart is enabled.
    assign w_restart = c_RESTART_EN & Bandera;

    // Sequencer: state, term/dwell/function counters and registered flag outputs.
    // k and f are forced to 0 outside RUN so the selects can be driven straight
    // from the counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_d       <= '0;
            r_f       <= '0;
            r_clr     <= 1'b0;
            r_ocupado <= 1'b0;
            r_listo   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Bandera) begin
                        r_state   <= ST_CLEAR;
                        r_clr     <= 1'b1;
                        r_ocupado <= 1'b1;
                    end
                end

                ST_CLEAR: begin
                    r_k <= '0;
                    r_d <= '0;
                    r_f <= '0;
                    if (w_restart) begin
                        r_state <= ST_CLEAR;
                    end else begin
                        r_state <= ST_RUN;
                        r_clr   <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (w_restart) begin
                        r_state <= ST_CLEAR;
                        r_clr   <= 1'b1;
                        r_k     <= '0;
                        r_d     <= '0;
                        r_f     <= '0;
                    end else if (!Hold) begin
                        if (r_d == c_D_LAST) begin
                            r_d <= '0;
                            if (r_k == c_K_LAST) begin
                                r_state <= ST_DONE;
                                r_listo <= 1'b1;
                                r_k     <= '0;
                                r_f     <= '0;
                            end else begin
                                r_k <= r_k + c_K_ONE;
                                r_f <= (r_f == c_F_LAST) ? '0 : r_f + c_F_ONE;
                            end
                        end else begin
                            r_d <= r_d + c_D_ONE;
                        end
                    end
                end

                ST_DONE: begin
                    r_listo <= 1'b0;
                    if (w_restart) begin
                        r_state <= ST_CLEAR;
                        r_clr   <= 1'b1;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_ocupado <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_k       <= '0;
                    r_d       <= '0;
                    r_f       <= '0;
                    r_clr     <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_listo   <= 1'b0;
                end
            endcase
        end
    end

    assign sel_const  = r_k;
    assign sel_fun    = r_f;
    assign clr_acum   = r_clr;
    assign Ocupado    = r_ocupado;
    assign Band_Listo = r_listo;
    // Accumulate only while running and not stalled; the sole input-to-output path.
    assign sel_acum   = (r_state == ST_RUN) & ~Hold;

endmodule
`default_nettype wire

// File: tb/tb_secuenciador_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_secuenciador_mac
// Description : Directed self-checking bench for secuenciador_mac. Three
//               instances cover default, DWELL=2 and 9-term/4-function
//               configurations. Restart expectations follow the
//               SECUENCIADOR_MAC_RESTART_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secuenciador_mac;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance 0: defaults
    logic       band0, hold0;
    logic [2:0] sc0;
    logic [1:0] sf0;
    logic       sa0, cl0, oc0, bl0;
    // Instance 1: DWELL=2
    logic       band1, hold1;
    logic [2:0] sc1;
    logic [1:0] sf1;
    logic       sa1, cl1, oc1, bl1;
    // Instance 2: NUM_TERMS=9, CONST_W=4, FUN_CNT=4
    logic       band2, hold2;
    logic [3:0] sc2;
    logic [1:0] sf2;
    logic       sa2, cl2, oc2, bl2;

    int vectors     = 0;
    int miscompares = 0;

    secuenciador_mac dut0 (
        .clk(clk), .rst_n(rst_n), .Bandera(band0), .Hold(hold0),
        .sel_const(sc0), .sel_fun(sf0), .sel_acum(sa0), .clr_acum(cl0),
        .Ocupado(oc0), .Band_Listo(bl0)
    );

    secuenciador_mac #(.DWELL(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .Bandera(band1), .Hold(hold1),
        .sel_const(sc1), .sel_fun(sf1), .sel_acum(sa1), .clr_acum(cl1),
        .Ocupado(oc1), .Band_Listo(bl1)
    );

    secuenciador_mac #(.NUM_TERMS(9), .CONST_W(4), .FUN_CNT(4), .FUN_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .Bandera(band2), .Hold(hold2),
        .sel_const(sc2), .sel_fun(sf2), .sel_acum(sa2), .clr_acum(cl2),
        .Ocupado(oc2), .Band_Listo(bl2)
    );

    // Expected {sel_const, sel_fun, sel_acum, clr_acum, Ocupado, Band_Listo}
    // for a default run, cycle 1 being the CLEAR cycle.
    function automatic logic [8:0] exp_run0(input int cyc);
        int k;
        if (cyc == 1) return {3'd0, 2'd0, 4'b0110};
        if (cyc >= 2 && cyc <= 7) begin
            k = cyc - 2;
            return {3'(k), 2'(k % 3), 4'b1010};
        end
        if (cyc == 8) return {3'd0, 2'd0, 4'b0011};
        return 9'd0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [8:0] obs0, obs1;
        logic [9:0] obs2;
        rst_n = 1'b0;
        band0 = 1'b1; band1 = 1'b1; band2 = 1'b1;
        hold0 = 1'b0; hold1 = 1'b0; hold2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs0 = {sc0, sf0, sa0, cl0, oc0, bl0};
        obs1 = {sc1, sf1, sa1, cl1, oc1, bl1};
        obs2 = {sc2, sf2, sa2, cl2, oc2, bl2};
        vectors++;
        if (obs0 !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_dut0: got %h expected %h", obs0, 9'd0);
        end
        vectors++;
        if (obs1 !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_dut1: got %h expected %h", obs1, 9'd0);
        end
        vectors++;
        if (obs2 !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_dut2: got %h expected %h", obs2, 10'd0);
        end
        band0 = 1'b0; band1 = 1'b0; band2 = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sequence;
        logic [8:0] obs;
        band0 = 1'b1;
        tick();
        band0 = 1'b0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            #1;
            obs = {sc0, sf0, sa0, cl0, oc0, bl0};
            vectors++;
            if (obs !== exp_run0(cyc)) begin
                miscompares++;
                $display("FAIL sequence cyc %0d: got %h expected %h", cyc, obs, exp_run0(cyc));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] obs;
        band0 = 1'b1;
        tick();
        band0 = 1'b0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            // Start request raised during the IDLE cycle right after DONE.
            if (cyc == 9) band0 = 1'b1;
            #1;
            obs = {sc0, sf0, sa0, cl0, oc0, bl0};
            vectors++;
            if (obs !== exp_run0(cyc)) begin
                miscompares++;
                $display("FAIL b2b_first cyc %0d: got %h expected %h", cyc, obs, exp_run0(cyc));
            end
            tick();
        end
        band0 = 1'b0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            #1;
            obs = {sc0, sf0, sa0, cl0, oc0, bl0};
            vectors++;
            if (obs !== exp_run0(cyc)) begin
                miscompares++;
                $display("FAIL b2b_second cyc %0d: got %h expected %h", cyc, obs, exp_run0(cyc));
            end
            tick();
        end
    endtask

    task automatic test_stall;
        logic [8:0] obs, want;
        int k;
        band1 = 1'b1;
        tick();
        band1 = 1'b0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            // Stall for three cycles while k=2, d=1 (cycles 7..9).
            hold1 = (cyc >= 7 && cyc <= 9);
            if (cyc == 1)       want = {3'd0, 2'd0, 4'b0110};
            else if (cyc <= 16) begin
                if (cyc <= 7)       k = (cyc - 2) / 2;
                else if (cyc <= 10) k = 2;
                else                k = (cyc - 5) / 2;
                want = {3'(k), 2'(k % 3), (cyc >= 7 && cyc <= 9) ? 4'b0010 : 4'b1010};
            end
            else if (cyc == 17) want = {3'd0, 2'd0, 4'b0011};
            else                want = 9'd0;
            #1;
            obs = {sc1, sf1, sa1, cl1, oc1, bl1};
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL stall cyc %0d: got %h expected %h", cyc, obs, want);
            end
            tick();
        end
        hold1 = 1'b0;
    endtask

    task automatic test_wrap;
        logic [9:0] obs, want;
        int k;
        band2 = 1'b1;
        tick();
        band2 = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 1) want = {4'd0, 2'd0, 4'b0110};
            else if (cyc <= 10) begin
                k = cyc - 2;
                want = {4'(k), 2'(k % 4), 4'b1010};
            end
            else if (cyc == 11) want = {4'd0, 2'd0, 4'b0011};
            else                want = 10'd0;
            #1;
            obs = {sc2, sf2, sa2, cl2, oc2, bl2};
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL wrap cyc %0d: got %h expected %h", cyc, obs, want);
            end
            tick();
        end
    endtask

    task automatic test_restart;
        logic [8:0] obs, want;
        band0 = 1'b1;
        tick();
        band0 = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            // Second start raised while k=3 (cycle 5).
            band0 = (cyc == 5);
`ifdef SECUENCIADOR_MAC_RESTART_EN
            want = (cyc <= 5) ? exp_run0(cyc) : exp_run0(cyc - 5);
`else
            want = exp_run0(cyc);
`endif
            #1;
            obs = {sc0, sf0, sa0, cl0, oc0, bl0};
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL restart cyc %0d: got %h expected %h", cyc, obs, want);
            end
            tick();
        end
        band0 = 1'b0;
    endtask

    task automatic test_async_reset;
        logic [8:0] obs;
        band0 = 1'b1;
        tick();
        band0 = 1'b0;
        repeat (5) tick();
        // Now in cycle 6 (k=4); assert reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        obs = {sc0, sf0, sa0, cl0, oc0, bl0};
        vectors++;
        if (obs !== 9'd0) begin
            miscompares++;
            $display("FAIL async_reset_immediate: got %h expected %h", obs, 9'd0);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            obs = {sc0, sf0, sa0, cl0, oc0, bl0};
            vectors++;
            if (obs !== 9'd0) begin
                miscompares++;
                $display("FAIL async_reset_quiet %0d: got %h expected %h", i, obs, 9'd0);
            end
            tick();
        end
        band0 = 1'b1;
        tick();
        band0 = 1'b0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            #1;
            obs = {sc0, sf0, sa0, cl0, oc0, bl0};
            vectors++;
            if (obs !== exp_run0(cyc)) begin
                miscompares++;
                $display("FAIL async_rerun cyc %0d: got %h expected %h", cyc, obs, exp_run0(cyc));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_restart();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/secuenciador_mac.md
# secuenciador_mac

Parametrised control sequencer that drives the constant-select, function-select and accumulator-control lines of the multiply-accumulate datapath for an N-term evaluation. It is the successor to the fixed six-step control mux. It adds:
- configurable term count, dwell time and function rotation;
- an explicit accumulator clear, a stall input, a busy flag and a one-cycle done pulse.

It sits between the top-level start logic and the constant/function multiplexers and the accumulator.

## Interface
- NUM_TERMS, 6: number of terms summed per run. Range 1..2^CONST_W.
- CONST_W, 3: width of sel_const.
- FUN_CNT, 3: number of distinct function selects, rotated in order. Range 1..2^FUN_W.
- FUN_W, 2: width of sel_fun.
- DWELL, 1: cycles each term step is held (≥1).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- Bandera  in  1  start request, sampled on the rising clk edge.
- Hold  in  1  stall; freezes sequencing while high.
- sel_const  out  CONST_W  constant multiplexer select.
- sel_fun  out  FUN_W  function multiplexer select.
- sel_acum  out  1  accumulator enable (add term).
- clr_acum  out  1  accumulator synchronous clear.
- Ocupado  out  1  sequence in progress.
- Band_Listo  out  1  one-cycle done pulse.

## Operation
- FSM states are IDLE, CLEAR, RUN and DONE. Internal counters:
  - step k, range 0..NUM_TERMS-1;
  - dwell counter d, range 0..DWELL-1;
  - function index f, range 0..FUN_CNT-1, wrapping to 0 after FUN_CNT-1.
- IDLE: all outputs 0. Bandera=1 → CLEAR.
- CLEAR: lasts one cycle and is unaffected by Hold.
  - clr_acum=1, Ocupado=1; sel_const=0, sel_fun=0, sel_acum=0.
  - Resets k, d and f to 0. Next state is RUN.
- RUN:
  - sel_const=k, sel_fun=f, Ocupado=1.
  - sel_acum = ~Hold. This is the only combinational input→output path.
  - When Hold=0: d increments. At d=DWELL-1: d→0, k→k+1, f→f+1 (wrapping).
  - At k=NUM_TERMS-1 with d=DWELL-1 and Hold=0 → DONE.
  - When Hold=1: k, d and f are frozen; sel_const and sel_fun keep their values.
- DONE: lasts one cycle.
  - Band_Listo=1, Ocupado=1, other outputs 0.
  - Next state is IDLE. Hold is ignored in this state.
- Bandera while in CLEAR, RUN or DONE: behaviour depends on configuration (see below).
- Width rules:
  - sel_const carries k zero-extended to CONST_W.
  - sel_fun carries f zero-extended to FUN_W.
  - The dwell counter is $clog2(DWELL) bits wide, with a minimum of 1.
- Reset: asynchronous assertion of rst_n=0 at any time, including mid-run.
  - State → IDLE; k, d and f → 0.
  - All outputs → 0 immediately, with no clock required.
  - After release, the block waits in IDLE for Bandera.

## Timing
- Bandera is sampled high at edge E0. Then:
  - CLEAR occupies cycle E0→E1;
  - RUN occupies edges E1 to E(1+NUM_TERMS·DWELL+H), where H = number of cycles with Hold high;
  - Band_Listo is high for the single cycle following edge E(1+NUM_TERMS·DWELL+H).
- Latency from start to done, with no stall: NUM_TERMS·DWELL+2 cycles. With the defaults this is 8.
- Ocupado rises the cycle after E0 and falls with the cycle after Band_Listo.
- Back-to-back runs: the earliest new start is Bandera sampled in IDLE, the cycle after DONE.
- All outputs except sel_acum are decoded from registers only, so they are glitch-free with respect to the inputs.

## Configuration
- Macro: SECUENCIADOR_MAC_RESTART_EN.
- Defined: Bandera=1 sampled in CLEAR, RUN or DONE → CLEAR on the next cycle. k, d and f restart at 0, and Band_Listo is not produced for the aborted run.
- Undefined: Bandera is ignored outside IDLE and the current run completes normally.

## Test plan
- Reset, defaults (NUM_TERMS=6, DWELL=1):
  - stimulus: rst_n low, then release, then pulse Bandera;
  - response: all outputs 0 during reset. clr_acum=1 in cycle 1. sel_const goes 0,1,2,3,4,5 with sel_fun 0,1,2,0,1,2 and sel_acum=1 in cycles 2–7. Band_Listo=1 only in cycle 8. Ocupado=1 in cycles 1–8.
- Stall: with DWELL=2, hold Hold high for 3 cycles at k=2, d=1.
  - response: sel_const stays 2 and sel_acum=0 for those 3 cycles. Band_Listo arrives at cycle 6·2+2+3=17.
- Wrap and width: NUM_TERMS=9, CONST_W=4, FUN_CNT=4.
  - response: sel_const counts 0..8. sel_fun goes 0,1,2,3,0,1,2,3,0. Done at cycle 11.
- Restart, with the macro defined: Bandera pulsed again at k=3.
  - response: the next cycle is CLEAR (clr_acum=1), the sequence restarts at 0, and only one Band_Listo appears, at 8 cycles after the second start.
- Restart, with the macro undefined: the same stimulus.
  - response: the run continues and Band_Listo occurs at the original cycle 8.
- Asynchronous reset mid-run at k=4:
  - response: outputs go to 0 before the next edge and no Band_Listo is produced. A fresh Bandera then yields a normal 8-cycle run.
